fetch_ctrl: RTL and testbench

Instruction-fetch controller that owns the program counter register and sequences it against a single-ported instruction memory using a req/ack handshake. It holds one fetched instruction for decode and honours decode stalls. It accepts branch/jump redirects from the PC-select path and discards in-flight fetches made stale by a redirect. It sits between the PC next-address logic and the decode stage.

---
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, runs the imem req/ack handshake and holds one slot for decode.
// Optional exception entry is compiled in with FETCH_CTRL_EXC_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_CTRL_EXC_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
`endif
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr
`ifdef FETCH_CTRL_EXC_EN
  , input  logic        exc,
  output logic [31:0] exc_epc
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_instr_q, slot_instr_d;

  logic        exc_hit;
  logic        flush;
  logic [31:0] flush_pc;

`ifdef FETCH_CTRL_EXC_EN
  logic [31:0] epc_q, epc_d;

  assign exc_hit  = exc;
  assign flush_pc = exc ? EXC_VECTOR : redirect_pc;

  always_comb begin
    epc_d = epc_q;
    if (exc) epc_d = valid_q ? slot_pc_q : pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) epc_q <= 32'h0;
    else       epc_q <= epc_d;
  end

  assign exc_epc = epc_q;
`else
  assign exc_hit  = 1'b0;
  assign flush_pc = redirect_pc;
`endif

  assign flush = exc_hit | redirect;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    drop_d       = drop_q;
    valid_d      = valid_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    imem_req     = 1'b0;

    if (valid_q && !stall) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          drop_d  = 1'b0;
          state_d = ST_REQ;
          if (!drop_q && !flush) begin
            valid_d      = 1'b1;
            slot_pc_d    = addr_q;
            slot_instr_d = imem_rdata;
            pc_d         = pc_q + 32'd4;
            state_d      = ST_WAIT;
          end
        end else if (flush) begin
          // Request must stay up on its old address; its data is thrown away on ack.
          drop_d = 1'b1;
        end
      end
      ST_WAIT: begin
        imem_req = (!valid_q || !stall) && !flush;
        if (imem_req || flush) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      pc_d    = flush_pc;
      valid_d = 1'b0;
    end

    // Latch the address only when a fresh request begins so it stays frozen until ack.
    if (state_d == ST_REQ && (state_q != ST_REQ || imem_ack)) addr_d = {pc_d[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= {RESET_PC[31:2], 2'b00};
      drop_q       <= 1'b0;
      valid_q      <= 1'b0;
      slot_pc_q    <= 32'h0;
      slot_instr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      drop_q       <= drop_d;
      valid_q      <= valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
    end
  end

  assign imem_addr   = (state_q == ST_REQ) ? addr_q : {pc_q[31:2], 2'b00};
  assign if_valid    = valid_q;
  assign if_pc       = slot_pc_q;
  assign if_pc_plus4 = slot_pc_q + 32'd4;
  assign if_instr    = slot_instr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a transaction-level fetch model checked every cycle plus directed literals.
// Exception scenarios are exercised only when FETCH_CTRL_EXC_EN is defined.
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        exc;
  logic [31:0] exc_epc;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int mem_age = 0;

  // Fetch model state: program counter, outstanding request and the decode slot.
  logic        m_known = 1'b0;
  logic        m_boot;
  logic        m_pend;
  logic        m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_req_addr;
  logic        m_slot_v;
  logic [31:0] m_slot_pc;
  logic [31:0] m_slot_ins;
  logic [31:0] m_epc;

  fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr)
`ifdef FETCH_CTRL_EXC_EN
    , .exc(exc), .exc_epc(exc_epc)
`endif
  );

`ifndef FETCH_CTRL_EXC_EN
  assign exc_epc = 32'h0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Memory acks once a request has been up for mem_lat cycles; inputs change 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic rd,
                               input logic [31:0] rpc, input logic ex);
    if (reset || imem_req !== 1'b1 || imem_ack) mem_age = 0;
    else mem_age++;
    @(posedge clk);
    #1;
    reset       = rst;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    exc         = ex;
    imem_ack    = (mem_age >= mem_lat);
    imem_rdata  = imem_ack ? word(imem_addr) : 32'h0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin : compare_proc
    logic        exc_m;
    logic        flush_m;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    exc_m    = EXC_ON && exc;
    flush_m  = redirect || exc_m;
    tgt      = exc_m ? 32'h0000_0180 : redirect_pc;
    exp_req  = m_boot ? 1'b0 : (m_pend ? 1'b1 : ((!m_slot_v || !stall) && !flush_m));
    exp_addr = m_pend ? m_req_addr : {m_pc[31:2], 2'b00};
    if (m_known) begin
      checkOutput("model_req", {31'h0, imem_req}, {31'h0, exp_req});
      checkOutput("model_addr", imem_addr, exp_addr);
      checkOutput("model_valid", {31'h0, if_valid}, {31'h0, m_slot_v});
      if (m_slot_v) begin
        checkOutput("model_if_pc", if_pc, m_slot_pc);
        checkOutput("model_pc_plus4", if_pc_plus4, m_slot_pc + 32'd4);
        checkOutput("model_instr", if_instr, m_slot_ins);
      end
      if (EXC_ON) checkOutput("model_epc", exc_epc, m_epc);
    end
    if (reset) begin
      m_known = 1'b1; m_boot = 1'b1; m_pend = 1'b0; m_stale = 1'b0;
      m_pc = 32'h0; m_req_addr = 32'h0; m_slot_v = 1'b0;
      m_slot_pc = 32'h0; m_slot_ins = 32'h0; m_epc = 32'h0;
    end else if (m_known) begin
      if (exc_m) m_epc = m_slot_v ? m_slot_pc : m_pc;
      if (m_slot_v && !stall) m_slot_v = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
        if (flush_m) m_pc = tgt;
        m_pend = 1'b1;
        m_req_addr = {m_pc[31:2], 2'b00};
      end else if (m_pend) begin
        if (imem_ack && !m_stale && !flush_m) begin
          m_slot_v = 1'b1; m_slot_pc = m_req_addr; m_slot_ins = word(m_req_addr);
          m_pc = m_pc + 32'd4; m_pend = 1'b0;
        end else if (imem_ack) begin
          if (flush_m) begin m_pc = tgt; m_slot_v = 1'b0; end
          m_stale = 1'b0;
          m_req_addr = {m_pc[31:2], 2'b00};
        end else if (flush_m) begin
          m_pc = tgt; m_stale = 1'b1; m_slot_v = 1'b0;
        end
      end else if (flush_m) begin
        m_pc = tgt; m_slot_v = 1'b0; m_pend = 1'b1; m_req_addr = {tgt[31:2], 2'b00};
      end else if (exp_req) begin
        m_pend = 1'b1; m_req_addr = {m_pc[31:2], 2'b00};
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    logic found;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    exc = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;

    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0);
    checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_instr", if_instr, 32'h0);
    if (EXC_ON) checkOutput("rst_epc", exc_epc, 32'h0);

    $display("[TB] sequential fetch and stall");
    mem_lat = 1;
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("idle_req", {31'h0, imem_req}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("first_req", {31'h0, imem_req}, 32'h1);
    checkOutput("first_addr", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("slot0_valid", {31'h0, if_valid}, 32'h1);
    checkOutput("slot0_pc", if_pc, 32'h0);
    checkOutput("slot0_instr", if_instr, 32'hC0DE_0000);
    checkOutput("req4_addr", imem_addr, 32'h4);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("gap_valid", {31'h0, if_valid}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 32'h0, 0);
      checkOutput("stall_req", {31'h0, imem_req}, 32'h0);
      checkOutput("stall_pc", if_pc, 32'h4);
      checkOutput("stall_instr", if_instr, 32'hC0DE_0004);
    end
    mem_lat = 3;
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("release_req", {31'h0, imem_req}, 32'h1);
    checkOutput("release_addr", imem_addr, 32'h8);

    $display("[TB] redirect with outstanding request");
    applyStimulus(0, 0, 1, 32'h100, 0);
    checkOutput("redir_hold_addr", imem_addr, 32'h8);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("redir_still_addr", imem_addr, 32'h8);
    applyStimulus(0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("after_stale_req", {31'h0, imem_req}, 32'h1);
    checkOutput("after_stale_addr", imem_addr, 32'h100);
    checkOutput("after_stale_valid", {31'h0, if_valid}, 32'h0);
    mem_lat = 1;
    applyStimulus(0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("redir_slot_pc", if_pc, 32'h100);
    checkOutput("redir_slot_instr", if_instr, 32'hC0DE_0100);

    $display("[TB] reset mid-request");
    mem_lat = 3;
    applyStimulus(0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0);
    mem_lat = 1;
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("mid_rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("mid_rst_addr", imem_addr, 32'h0);
    checkOutput("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("mid_rst_if_pc", if_pc, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("mid_rst_first_addr", imem_addr, 32'h0);

    $display("[TB] redirect coinciding with ack");
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      applyStimulus(0, 0, 0, 32'h0, 0);
      if (imem_req && imem_addr == 32'hC) begin found = 1'b1; break; end
    end
    checkOutput("reach_req_c", {31'h0, found}, 32'h1);
    applyStimulus(0, 0, 1, 32'h200, 0);
    checkOutput("coincide_addr", imem_addr, 32'hC);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("coincide_next_addr", imem_addr, 32'h200);
    checkOutput("coincide_valid", {31'h0, if_valid}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 1, 32'h103, 0);
    checkOutput("slot200_pc", if_pc, 32'h200);
    checkOutput("redir_wait_req", {31'h0, imem_req}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("misalign_addr", imem_addr, 32'h100);
    applyStimulus(0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("misalign_if_pc", if_pc, 32'h100);
    checkOutput("misalign_plus4", if_pc_plus4, 32'h104);

`ifdef FETCH_CTRL_EXC_EN
    $display("[TB] exception beats redirect");
    applyStimulus(1, 0, 0, 32'h0, 0);
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      applyStimulus(0, 0, 0, 32'h0, 0);
      if (if_valid && if_pc == 32'hC) begin found = 1'b1; break; end
    end
    checkOutput("reach_slot_c", {31'h0, found}, 32'h1);
    applyStimulus(0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 1, 32'h300, 1);
    checkOutput("exc_pre_pc", if_pc, 32'h10);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("exc_epc_val", exc_epc, 32'h10);
    checkOutput("exc_vec_addr", imem_addr, 32'h180);
    checkOutput("exc_valid", {31'h0, if_valid}, 32'h0);
`endif

    $display("[TB] mixed stall traffic");
    mem_lat = 2;
    for (int i = 0; i < 40; i++)
      applyStimulus(0, (i % 3) == 1, i == 17, 32'h400, EXC_ON && i == 29);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
